// File: rtl/mem_io_ctrl_if.sv
// CPU data-memory bus plus the output stream port of mem_io_ctrl.
// Stream handshake: a word transfers on a rising clk edge where out_valid && out_ready; out_data holds while out_valid && !out_ready.
interface mem_io_ctrl_if;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output DataAdr, WriteData, MemWrite, out_ready,
        input  ReadData, out_data, out_valid
    );

    modport slave (
        input  DataAdr, WriteData, MemWrite, out_ready,
        output ReadData, out_data, out_valid
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// Data RAM plus memory-mapped output FIFO, STATUS and free-running CYCLE counter
// for a single-cycle CPU; loads are combinational from DataAdr.
module mem_io_ctrl #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_io_ctrl_if.slave bus
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    logic [31:0] ram_mem  [RAM_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;

    logic [29:0]    word_adr;
    logic [RAW-1:0] ram_idx;
    logic           is_ram, is_out, is_status, is_cycle;
    logic           push, pop, full, empty, fifo_we;
    logic [3:0]     cnt_sat;
    logic           unused_adr_bits;

    assign word_adr        = bus.DataAdr[31:2];
    assign ram_idx         = bus.DataAdr[RAW+1:2];
    assign unused_adr_bits = &{1'b0, bus.DataAdr[1:0]};

    assign is_ram    = {2'b00, word_adr} < 32'(RAM_WORDS);
    assign is_out    = word_adr == 30'h100;
    assign is_status = word_adr == 30'h101;
    assign is_cycle  = word_adr == 30'h102;

    assign full  = count_q == CW'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign push  = bus.MemWrite && is_out;
    assign pop   = !empty && bus.out_ready;

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 32'd0 : fifo_mem[rd_ptr_q];
    assign cnt_sat       = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);

    always_comb begin
        bus.ReadData = 32'd0;
        if (is_ram)
            bus.ReadData = ram_mem[ram_idx];
        else if (is_status)
            bus.ReadData = {23'd0, ovf_q, cnt_sat, 2'b00, full, empty};
        else if (is_cycle)
            bus.ReadData = cycle_q;
    end

    // A push that coincides with a pop is always taken, even when full:
    // the head slot being vacated is exactly the slot the write pointer names.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        fifo_we  = 1'b0;
        cycle_d  = (bus.MemWrite && is_cycle) ? bus.WriteData : cycle_q + 32'd1;

        if (push && (pop || !full)) begin
            fifo_we  = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        if (push && !pop && !full)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        if (push && !pop && full)
            ovf_d = 1'b1;
        else if (bus.MemWrite && is_status && bus.WriteData[8])
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
        end
    end

    // Storage arrays carry no reset; their contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && is_ram)
            ram_mem[ram_idx] <= bus.WriteData;
        if (fifo_we)
            fifo_mem[wr_ptr_q] <= bus.WriteData;
    end
endmodule
